// File: rtl/mmu_tlb_assoc.sv
// Set-associative TLB: two 4 KB PTEs per line, ASID/global tagging, true-LRU
// replacement, fill-in-place and selective invalidation. One-cycle lookup.
module mmu_tlb_assoc #(
  parameter int P_WAYS   = 4,
  parameter int P_SET_W  = 2,
  parameter int P_ASID_W = 8
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iINV_REQ,
  input  logic [1:0]          iINV_MODE,
  input  logic [P_ASID_W-1:0] iINV_ASID,
  input  logic [31:0]         iINV_ADDR,
  input  logic                iRD_REQ,
  output logic                oRD_BUSY,
  input  logic [P_ASID_W-1:0] iRD_ASID,
  input  logic [31:0]         iRD_ADDR,
  output logic                oRD_VALID,
  input  logic                iRD_BUSY,
  output logic                oRD_HIT,
  output logic [11:0]         oRD_FLAGS,
  output logic [31:0]         oRD_PHYS_ADDR,
  input  logic                iWR_REQ,
  input  logic [P_ASID_W-1:0] iWR_ASID,
  input  logic                iWR_GLOBAL,
  input  logic [31:0]         iWR_ADDR,
  input  logic [63:0]         iWR_PHYS_ADDR
);

  localparam int L_WAY_W = (P_WAYS > 1) ? $clog2(P_WAYS) : 1;
  localparam int L_SETS  = 1 << P_SET_W;
  localparam int L_TAG_W = 19 - P_SET_W;
  localparam logic [L_WAY_W-1:0] L_AGE_TOP = L_WAY_W'(P_WAYS - 1);

  logic                valid_q [L_SETS][P_WAYS];
  logic [L_WAY_W-1:0]  age_q   [L_SETS][P_WAYS];
  logic [L_TAG_W-1:0]  tag_q   [L_SETS][P_WAYS];
  logic [P_ASID_W-1:0] asid_q  [L_SETS][P_WAYS];
  logic                glob_q  [L_SETS][P_WAYS];
  logic [19:0]         frame_q [L_SETS][P_WAYS][2];
  logic [11:0]         flags_q [L_SETS][P_WAYS][2];

  logic [P_SET_W-1:0] rd_idx, wr_idx, inv_idx;
  logic [L_TAG_W-1:0] rd_tag, wr_tag, inv_tag;

  assign rd_idx  = iRD_ADDR[13 +: P_SET_W];
  assign wr_idx  = iWR_ADDR[13 +: P_SET_W];
  assign inv_idx = iINV_ADDR[13 +: P_SET_W];
  assign rd_tag  = iRD_ADDR[31 -: L_TAG_W];
  assign wr_tag  = iWR_ADDR[31 -: L_TAG_W];
  assign inv_tag = iINV_ADDR[31 -: L_TAG_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iINV_ADDR[12:0], iWR_ADDR[12:0]};

  // Lookup match against the array state before this cycle's updates.
  logic               rd_hit;
  logic [L_WAY_W-1:0] rd_way;

  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int w = P_WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag) &&
          (glob_q[rd_idx][w] || (asid_q[rd_idx][w] == iRD_ASID))) begin
        rd_hit = 1'b1;
        rd_way = L_WAY_W'(w);
      end
    end
  end

  // Fill victim: matching way, else lowest invalid way, else the age-0 way.
  logic               wr_match, wr_free, fill_new;
  logic [L_WAY_W-1:0] wr_match_way, wr_free_way, wr_old_way, fill_way;

  always_comb begin
    wr_match     = 1'b0;
    wr_free      = 1'b0;
    wr_match_way = '0;
    wr_free_way  = '0;
    wr_old_way   = '0;
    for (int w = P_WAYS - 1; w >= 0; w--) begin
      if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag) &&
          (glob_q[wr_idx][w] || (asid_q[wr_idx][w] == iWR_ASID))) begin
        wr_match     = 1'b1;
        wr_match_way = L_WAY_W'(w);
      end
      if (!valid_q[wr_idx][w]) begin
        wr_free     = 1'b1;
        wr_free_way = L_WAY_W'(w);
      end
      if (age_q[wr_idx][w] == '0) begin
        wr_old_way = L_WAY_W'(w);
      end
    end
    if (wr_match) begin
      fill_way = wr_match_way;
      fill_new = 1'b0;
    end else if (wr_free) begin
      fill_way = wr_free_way;
      fill_new = 1'b1;
    end else begin
      fill_way = wr_old_way;
      fill_new = 1'b0;
    end
  end

  // Per-entry invalidate mask; mode 2 picks at most one way.
  logic               inv_act;
  logic               inv_clr [L_SETS][P_WAYS];
  logic               inv_hit;
  logic [L_WAY_W-1:0] inv_way;

  assign inv_act = iINV_REQ && (iINV_MODE != 2'd3);

  always_comb begin
    inv_hit = 1'b0;
    inv_way = '0;
    for (int w = P_WAYS - 1; w >= 0; w--) begin
      if (valid_q[inv_idx][w] && (tag_q[inv_idx][w] == inv_tag) &&
          (glob_q[inv_idx][w] || (asid_q[inv_idx][w] == iINV_ASID))) begin
        inv_hit = 1'b1;
        inv_way = L_WAY_W'(w);
      end
    end
    for (int s = 0; s < L_SETS; s++) begin
      for (int w = 0; w < P_WAYS; w++) begin
        inv_clr[s][w] = 1'b0;
        if (inv_act) begin
          case (iINV_MODE)
            2'd0:    inv_clr[s][w] = valid_q[s][w];
            2'd1:    inv_clr[s][w] = valid_q[s][w] && !glob_q[s][w] &&
                                     (asid_q[s][w] == iINV_ASID);
            2'd2:    inv_clr[s][w] = inv_hit && (P_SET_W'(s) == inv_idx) &&
                                     (L_WAY_W'(w) == inv_way);
            default: inv_clr[s][w] = 1'b0;
          endcase
        end
      end
    end
  end

  // Invalidate beats fill beats read touch; any invalidate strobe drops a fill.
  logic               fill_en, touch_en, upd_en, upd_new;
  logic [P_SET_W-1:0] upd_idx;
  logic [L_WAY_W-1:0] upd_way, upd_old;

  assign fill_en  = iWR_REQ && !iINV_REQ;
  assign touch_en = iRD_REQ && !iRD_BUSY && rd_hit && !iWR_REQ && !iINV_REQ;
  assign upd_en   = fill_en || touch_en;
  assign upd_idx  = fill_en ? wr_idx : rd_idx;
  assign upd_way  = fill_en ? fill_way : rd_way;
  assign upd_new  = fill_en && fill_new;
  assign upd_old  = age_q[upd_idx][upd_way];

  // Ages saturate at 0 so a set left partially valid by invalidation recovers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int s = 0; s < L_SETS; s++) begin
        for (int w = 0; w < P_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
      end
    end else if (inv_act) begin
      for (int s = 0; s < L_SETS; s++) begin
        for (int w = 0; w < P_WAYS; w++) begin
          if (inv_clr[s][w]) begin
            valid_q[s][w] <= 1'b0;
            age_q[s][w]   <= '0;
          end
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < P_WAYS; w++) begin
        if (L_WAY_W'(w) == upd_way) begin
          valid_q[upd_idx][w] <= 1'b1;
          age_q[upd_idx][w]   <= L_AGE_TOP;
        end else if (valid_q[upd_idx][w] && (age_q[upd_idx][w] != '0) &&
                     (upd_new || (age_q[upd_idx][w] > upd_old))) begin
          age_q[upd_idx][w] <= age_q[upd_idx][w] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (fill_en) begin
      tag_q[wr_idx][fill_way]      <= wr_tag;
      asid_q[wr_idx][fill_way]     <= iWR_ASID;
      glob_q[wr_idx][fill_way]     <= iWR_GLOBAL;
      frame_q[wr_idx][fill_way][0] <= iWR_PHYS_ADDR[31:12];
      flags_q[wr_idx][fill_way][0] <= iWR_PHYS_ADDR[11:0];
      frame_q[wr_idx][fill_way][1] <= iWR_PHYS_ADDR[63:44];
      flags_q[wr_idx][fill_way][1] <= iWR_PHYS_ADDR[43:32];
    end
  end

  // Lookup stage registers hold while downstream is busy.
  logic               req_q, hit_q, line_q;
  logic [L_WAY_W-1:0] way_q;
  logic [P_SET_W-1:0] idx_q;
  logic [11:0]        off_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      req_q  <= 1'b0;
      hit_q  <= 1'b0;
      line_q <= 1'b0;
      way_q  <= '0;
      idx_q  <= '0;
      off_q  <= '0;
    end else begin
      if (!iRD_BUSY) begin
        req_q  <= iRD_REQ;
        hit_q  <= rd_hit;
        line_q <= iRD_ADDR[12];
        way_q  <= rd_way;
        idx_q  <= rd_idx;
        off_q  <= iRD_ADDR[11:0];
      end
      if (inv_act) begin
        req_q <= 1'b0;
      end
    end
  end

  // Data comes from the live array so a fill landing after the lookup is seen.
  assign oRD_BUSY      = iRD_BUSY;
  assign oRD_VALID     = req_q && !iRD_BUSY;
  assign oRD_HIT       = oRD_VALID && hit_q;
  assign oRD_FLAGS     = oRD_HIT ? flags_q[idx_q][way_q][line_q] : 12'd0;
  assign oRD_PHYS_ADDR = oRD_HIT ? {frame_q[idx_q][way_q][line_q], off_q} : 32'd0;

endmodule

// File: doc/mmu_tlb_assoc.md
Name: mmu_tlb_assoc

Overview:
Parametrised N-way set-associative TLB for 4 KB level-2 pages with two PTEs per line. It adds ASID tagging, global entries, true-LRU replacement, write-hit update-in-place and selective invalidation. It sits between the MMU table walker (fill port) and the load/store address path (lookup port). Lookup has one-cycle latency with output hold under downstream backpressure.

Parameters:
P_WAYS, 4, associativity; power of 2, range 2..8.
P_SET_W, 2, log2 of set count (sets = 2^P_SET_W), range 1..4.
P_ASID_W, 8, ASID width.

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iINV_REQ  in  1  invalidate strobe, one cycle per request
iINV_MODE  in  2  0 = all; 1 = all non-global entries matching iINV_ASID; 2 = entry matching iINV_ADDR and (iINV_ASID or global); 3 = no-op
iINV_ASID  in  P_ASID_W  invalidate ASID
iINV_ADDR  in  32  invalidate virtual address
iRD_REQ  in  1  lookup request
oRD_BUSY  out  1  equals iRD_BUSY
iRD_ASID  in  P_ASID_W  lookup ASID
iRD_ADDR  in  32  lookup virtual address
oRD_VALID  out  1  lookup result valid
iRD_BUSY  in  1  downstream stall
oRD_HIT  out  1  lookup hit
oRD_FLAGS  out  12  PTE flags of the selected line
oRD_PHYS_ADDR  out  32  translated address
iWR_REQ  in  1  fill strobe
iWR_ASID  in  P_ASID_W  fill ASID
iWR_GLOBAL  in  1  entry matches any ASID
iWR_ADDR  in  32  fill virtual address
iWR_PHYS_ADDR  in  64  [63:32] = PTE for the odd page, [31:0] = PTE for the even page; each PTE is [31:12] frame, [11:0] flags

Behaviour:
- Address split: line = addr[12], index = addr[13 +: P_SET_W], tag = addr[31:13+P_SET_W].
- Entry contents: valid, tag, ASID, global, two frames (20 b each), two flag fields (12 b each), LRU age (log2(P_WAYS) bits).
- Match rule: valid && tag equal && (global || ASID equal).
- Reset: all entries invalid, ages 0, all output registers 0. Therefore oRD_VALID = oRD_HIT = 0, oRD_FLAGS = 0, oRD_PHYS_ADDR = 0.
- Lookup sampling: when iRD_BUSY = 0, each cycle registers iRD_REQ, hit, hit way, index, line and addr[11:0]. When iRD_BUSY = 1, these registers hold.
- Lookup results are visible the next cycle:
  - oRD_VALID = req_reg && !iRD_BUSY.
  - oRD_HIT = oRD_VALID && hit_reg.
  - On hit: oRD_PHYS_ADDR = {frame[line_reg], addr_reg[11:0]} and oRD_FLAGS = flags[line_reg].
  - Otherwise oRD_PHYS_ADDR and oRD_FLAGS are 0.
- Output data is read from the live array, so a fill to the same way in the intervening cycle is visible.
- Lookup compares against pre-update array state. A same-cycle fill or invalidate is not seen by that lookup.
- True LRU: each set holds distinct ages 0..P_WAYS-1 once full.
  - Touching way w with old age a: age[w] becomes P_WAYS-1; every other valid way in the set with age > a decrements.
  - Only that set changes.
- A touch happens on a read hit with iRD_REQ && !iRD_BUSY, provided no fill or invalidate occurs in that cycle.
- Fill way selection, in order:
  1. The matching way, if any (update in place, so no duplicates).
  2. Otherwise the lowest-index invalid way.
  3. Otherwise the way with age 0.
- Fill writes all fields, sets valid, and touches the filled way. For a newly valid way, treat its old age as -1 so all other valid ways in the set decrement.
- Priority per cycle: invalidate > fill > read-LRU touch. A fill in the same cycle as any invalidate is dropped; the walker must retry.
- Invalidation:
  - Effective at the next edge; clears valid only, and zeroes the ages of cleared ways.
  - Any iINV_REQ with mode != 3 also clears req_reg, so the lookup in flight returns no oRD_VALID.
  - Mode 2 clears at most one way.
- inRESET asserted mid-operation immediately forces every output to its reset value.

Test Plan:
1. Reset, then lookup ASID 1 at 0x0000_2000 -> one cycle later oRD_VALID = 1, oRD_HIT = 0, oRD_PHYS_ADDR = 0.
2. Fill ASID 1, VA 0x0000_2000, PTEs {0xABCDE_0F3, 0x12345_07A}, then lookup 0x0000_3456 -> oRD_HIT = 1, oRD_PHYS_ADDR = 0xABCDE456, oRD_FLAGS = 0x0F3. Lookup 0x0000_2010 -> 0x12345010, flags 0x07A.
3. Backpressure: hold iRD_BUSY = 1 for 3 cycles after a hit lookup -> oRD_VALID = 0 throughout. The result appears unchanged in the cycle iRD_BUSY drops.
4. LRU: fill 4 tags into index 1 (VA 0x2000 + k·0x8000, k = 0..3), hit k = 0, then fill k = 4 -> k = 1 is evicted, k = 0 still hits. Refilling k = 2 with new PTEs keeps a single matching way and returns the new frame.
5. ASID/global: fill VA 0x10000 as global and VA 0x18000 as ASID 2, then invalidate with mode 1, ASID 2 -> the global entry hits for ASID 5, and 0x18000 misses for ASID 2.
6. Simultaneous: invalidate mode 0 in the same cycle as a fill and a pending hit -> the next cycle has oRD_VALID = 0, and every later lookup misses.
